// File: rtl/timer_bus_ctrl_pkg.sv
// rtl/timer_bus_ctrl_pkg.sv - shared constants, reset values and FSM state type for the timer bus controller
package timer_pkg;

    // Register offsets within a channel (bus_addr[2:0])
    localparam logic [2:0] REG_TCNT     = 3'd0;
    localparam logic [2:0] REG_TCORA    = 3'd1;
    localparam logic [2:0] REG_TCORB    = 3'd2;
    localparam logic [2:0] REG_TCR      = 3'd3;
    localparam logic [2:0] REG_TCCR     = 3'd4;
    localparam logic [2:0] REG_TCSR     = 3'd5;
    localparam logic [2:0] REG_CNT16_LO = 3'd6;
    localparam logic [2:0] REG_CNT16_HI = 3'd7;

    // Register reset values
    localparam logic [7:0] TCOR_RST = 8'hFF;
    localparam logic [7:0] CTRL_RST = 8'h00;

    // TCSR bit positions
    localparam int TCSR_CMFB = 7;
    localparam int TCSR_CMFA = 6;
    localparam int TCSR_OVF  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACT  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/timer_bus_ctrl_if.sv
// rtl/timer_bus_ctrl_if.sv - CPU-side req/ack register bus for the timer block
interface timer_bus_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 bus_req;
    logic                 bus_we;
    logic [4:0]           bus_addr;
    logic [BIT_WIDTH-1:0] bus_wdata;
    logic [BIT_WIDTH-1:0] bus_rdata;
    logic                 bus_ack;
    logic                 bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/timer_bus_ctrl_tcsr_flags.sv
// rtl/timer_bus_ctrl_tcsr_flags.sv - one channel's CMFB/CMFA/OVF flags with read-arm / write-0 clear
module timer_tcsr_flags (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] set_pulse,  // {cmfb, cmfa, ovf}
    input  logic       rd_en,      // TCSR read completing this cycle
    input  logic       wr_en,      // TCSR write completing this cycle
    input  logic [2:0] wr_bits,    // written {cmfb, cmfa, ovf} bits
    output logic [2:0] flags
);
    logic [2:0] arm;
    logic [2:0] clr;

    // A flag clears only when it was armed by a read that saw it set and the write supplies 0
    assign clr = wr_en ? (arm & ~wr_bits) : 3'b000;

    // Flags: set pulses dominate clears; arm bits collect 1s seen on reads, any write disarms
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 3'b000;
            arm   <= 3'b000;
        end else begin
            flags <= set_pulse | (flags & ~clr);
            if (wr_en)
                arm <= 3'b000;
            else if (rd_en)
                arm <= arm | flags;
        end
    end
endmodule

// File: rtl/timer_bus_ctrl.sv
// rtl/timer_bus_ctrl.sv - timer register-access controller; optional TIMER_BUS_16BIT_EN adds cascaded 16-bit count reads
module timer_bus_ctrl
    import timer_pkg::*;
#(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CH      = 4,
    parameter int WAIT_STATES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    timer_bus_if.slave                  bus,
    input  logic [NUM_CH*BIT_WIDTH-1:0] tcnt_i,
    output logic [NUM_CH-1:0]           tcnt_wr_o,
    output logic [BIT_WIDTH-1:0]        tcnt_wdata_o,
    output logic [NUM_CH*BIT_WIDTH-1:0] tcora_o,
    output logic [NUM_CH*BIT_WIDTH-1:0] tcorb_o,
    output logic [NUM_CH*BIT_WIDTH-1:0] tcr_o,
    output logic [NUM_CH*BIT_WIDTH-1:0] tccr_o,
    output logic [NUM_CH*BIT_WIDTH-1:0] tcsr_o,
    input  logic [NUM_CH-1:0]           cmfa_set_i,
    input  logic [NUM_CH-1:0]           cmfb_set_i,
    input  logic [NUM_CH-1:0]           ovf_set_i
);
    // WAIT lasts WAIT_STATES cycles: counter starts at WAIT_STATES-1 and leaves at 0
    localparam logic [2:0] WS_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t state_q, state_d;
    logic [2:0] wcnt_q, wcnt_d;

    logic                 we_q;
    logic [4:0]           addr_q;
    logic [BIT_WIDTH-1:0] wdata_q;

    logic [NUM_CH-1:0][BIT_WIDTH-1:0] tcnt_v;
    logic [NUM_CH-1:0][BIT_WIDTH-1:0] tcora_q, tcorb_q, tcr_q, tccr_q, tcsr_v;
    logic [NUM_CH-1:0][3:0]           tcsr_os_q;
    logic [NUM_CH-1:0][2:0]           flags;

    logic [1:0]           ch_sel;
    logic [2:0]           reg_sel;
    logic                 act, rd_act, wr_act;
    logic                 cnt16_ok, reserved;
    logic [BIT_WIDTH-1:0] rdata_mux;

    assign tcnt_v  = tcnt_i;
    assign ch_sel  = addr_q[4:3];
    assign reg_sel = addr_q[2:0];
    assign act     = (state_q == ACT);
    assign rd_act  = act && !we_q;
    assign wr_act  = act && we_q;

`ifdef TIMER_BUS_16BIT_EN
    logic [BIT_WIDTH-1:0] temp_q;
    assign cnt16_ok = (reg_sel >= REG_CNT16_LO) && !ch_sel[0];
`else
    assign cnt16_ok = 1'b0;
`endif
    assign reserved = (reg_sel >= REG_CNT16_LO) && !cnt16_ok;

    // FSM state and wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state: 4-phase handshake, a held request only executes once
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.bus_req) begin
                    wcnt_d  = WS_LOAD;
                    state_d = (WAIT_STATES == 0) ? ACT : WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == 3'd0)
                    state_d = ACT;
                else
                    wcnt_d = wcnt_q - 3'd1;
            end
            ACT:     state_d = HOLD;
            HOLD:    if (!bus.bus_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the request fields when an access is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= 5'd0;
            wdata_q <= '0;
        end else if (state_q == IDLE && bus.bus_req) begin
            we_q    <= bus.bus_we;
            addr_q  <= bus.bus_addr;
            wdata_q <= bus.bus_wdata;
        end
    end

    // Register storage, written at the end of the ACT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tcora_q[c]   <= BIT_WIDTH'(TCOR_RST);
                tcorb_q[c]   <= BIT_WIDTH'(TCOR_RST);
                tcr_q[c]     <= BIT_WIDTH'(CTRL_RST);
                tccr_q[c]    <= BIT_WIDTH'(CTRL_RST);
                tcsr_os_q[c] <= 4'd0;
            end
        end else if (wr_act) begin
            case (reg_sel)
                REG_TCORA: tcora_q[ch_sel]   <= wdata_q;
                REG_TCORB: tcorb_q[ch_sel]   <= wdata_q;
                REG_TCR:   tcr_q[ch_sel]     <= wdata_q;
                REG_TCCR:  tccr_q[ch_sel]    <= wdata_q;
                REG_TCSR:  tcsr_os_q[ch_sel] <= wdata_q[3:0];
                default: ;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_flags
            timer_tcsr_flags u_flags (
                .clk       (clk),
                .rst       (rst),
                .set_pulse ({cmfb_set_i[g], cmfa_set_i[g], ovf_set_i[g]}),
                .rd_en     (rd_act && reg_sel == REG_TCSR && ch_sel == 2'(g)),
                .wr_en     (wr_act && reg_sel == REG_TCSR && ch_sel == 2'(g)),
                .wr_bits   ({wdata_q[TCSR_CMFB], wdata_q[TCSR_CMFA], wdata_q[TCSR_OVF]}),
                .flags     (flags[g])
            );
        end
    endgenerate

    // Assemble TCSR views: flags on top, bit4 reads 0, output-select in the low nibble
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            tcsr_v[c]            = '0;
            tcsr_v[c][TCSR_CMFB] = flags[c][2];
            tcsr_v[c][TCSR_CMFA] = flags[c][1];
            tcsr_v[c][TCSR_OVF]  = flags[c][0];
            tcsr_v[c][3:0]       = tcsr_os_q[c];
        end
    end

`ifdef TIMER_BUS_16BIT_EN
    // Upper byte of the cascaded count is frozen when the lower byte is read
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            temp_q <= '0;
        else if (rd_act && cnt16_ok && reg_sel == REG_CNT16_LO)
            temp_q <= tcnt_v[{ch_sel[1], 1'b1}];
    end
`endif

    // Read data select; reserved offsets fall through to 0
    always_comb begin
        rdata_mux = '0;
        case (reg_sel)
            REG_TCNT:  rdata_mux = tcnt_v[ch_sel];
            REG_TCORA: rdata_mux = tcora_q[ch_sel];
            REG_TCORB: rdata_mux = tcorb_q[ch_sel];
            REG_TCR:   rdata_mux = tcr_q[ch_sel];
            REG_TCCR:  rdata_mux = tccr_q[ch_sel];
            REG_TCSR:  rdata_mux = tcsr_v[ch_sel];
`ifdef TIMER_BUS_16BIT_EN
            REG_CNT16_LO: if (cnt16_ok) rdata_mux = tcnt_v[ch_sel];
            REG_CNT16_HI: if (cnt16_ok) rdata_mux = temp_q;
`endif
            default: rdata_mux = '0;
        endcase
    end

    // TCNT load strobe for the addressed channel, only during a TCNT write's ACT cycle
    always_comb begin
        tcnt_wr_o = '0;
        if (wr_act && reg_sel == REG_TCNT)
            tcnt_wr_o[ch_sel] = 1'b1;
    end

    assign bus.bus_ack   = act;
    assign bus.bus_err   = act && reserved;
    assign bus.bus_rdata = rd_act ? rdata_mux : '0;
    assign tcnt_wdata_o  = wdata_q;

    assign tcora_o = tcora_q;
    assign tcorb_o = tcorb_q;
    assign tcr_o   = tcr_q;
    assign tccr_o  = tccr_q;
    assign tcsr_o  = tcsr_v;

endmodule

// File: tb/tb_timer_bus_ctrl.sv
// tb/tb_timer_bus_ctrl.sv - directed self-checking bench for timer_bus_ctrl
module tb_timer_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tcnt_i;
    logic [3:0]  tcnt_wr_o;
    logic [7:0]  tcnt_wdata_o;
    logic [31:0] tcora_o, tcorb_o, tcr_o, tccr_o, tcsr_o;
    logic [3:0]  cmfa_set_i, cmfb_set_i, ovf_set_i;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int wr_cnt   = 0;

    always #5 clk = ~clk;

    timer_bus_if #(.BIT_WIDTH(8)) bus ();

    timer_bus_ctrl #(.BIT_WIDTH(8), .NUM_CH(4), .WAIT_STATES(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .tcnt_i       (tcnt_i),
        .tcnt_wr_o    (tcnt_wr_o),
        .tcnt_wdata_o (tcnt_wdata_o),
        .tcora_o      (tcora_o),
        .tcorb_o      (tcorb_o),
        .tcr_o        (tcr_o),
        .tccr_o       (tccr_o),
        .tcsr_o       (tcsr_o),
        .cmfa_set_i   (cmfa_set_i),
        .cmfb_set_i   (cmfb_set_i),
        .ovf_set_i    (ovf_set_i)
    );

    always @(negedge clk) begin
        if (bus.bus_ack === 1'b1) ack_cnt++;
        if (tcnt_wr_o !== 4'b0000) wr_cnt++;
    end

    task automatic do_access(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                             input logic [3:0] ovf_at_act,
                             output logic [7:0] rdata, output logic err,
                             output logic [3:0] wr_strobe, output logic [7:0] wr_data,
                             output int lat);
        @(negedge clk);
        bus.bus_req   = 1'b1;
        bus.bus_we    = we;
        bus.bus_addr  = addr;
        bus.bus_wdata = wdata;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.bus_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        rdata     = bus.bus_rdata;
        err       = bus.bus_err;
        wr_strobe = tcnt_wr_o;
        wr_data   = tcnt_wdata_o;
        ovf_set_i = ovf_at_act;
        bus.bus_req = 1'b0;
        @(negedge clk);
        ovf_set_i = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (tcora_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_tcora got %h want ffffffff", tcora_o); end
        n_checks++; if (tcorb_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_tcorb got %h want ffffffff", tcorb_o); end
        n_checks++; if (tcr_o !== 32'h0) begin n_fail++; $display("FAIL reset_tcr got %h want 0", tcr_o); end
        n_checks++; if (tccr_o !== 32'h0) begin n_fail++; $display("FAIL reset_tccr got %h want 0", tccr_o); end
        n_checks++; if (tcsr_o !== 32'h0) begin n_fail++; $display("FAIL reset_tcsr got %h want 0", tcsr_o); end
        n_checks++; if ({bus.bus_ack, bus.bus_err} !== 2'b00) begin n_fail++; $display("FAIL reset_ack_err got %b want 00", {bus.bus_ack, bus.bus_err}); end
        n_checks++; if (bus.bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", bus.bus_rdata); end
        n_checks++; if ({tcnt_wr_o, tcnt_wdata_o} !== 12'h000) begin n_fail++; $display("FAIL reset_tcnt_wr got %h want 000", {tcnt_wr_o, tcnt_wdata_o}); end
    endtask

    task automatic test_read_tcora();
        logic [7:0] rd, wd; logic er; logic [3:0] ws; int lat;
        do_access(1'b0, 5'b10001, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (rd !== 8'hFF) begin n_fail++; $display("FAIL read_tcora_data got %h want ff", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL read_tcora_err got %b want 0", er); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL read_latency got %0d want 2", lat); end
        n_checks++; if (bus.bus_rdata !== 8'h00) begin n_fail++; $display("FAIL rdata_cleared got %h want 00", bus.bus_rdata); end
    endtask

    task automatic test_tcnt_write();
        logic [7:0] rd, wd; logic er; logic [3:0] ws; int lat; int w0;
        w0 = wr_cnt;
        do_access(1'b1, 5'b01000, 8'h5A, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (ws !== 4'b0010) begin n_fail++; $display("FAIL tcnt_wr_strobe got %b want 0010", ws); end
        n_checks++; if (wd !== 8'h5A) begin n_fail++; $display("FAIL tcnt_wdata got %h want 5a", wd); end
        n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL tcnt_wr_cycles got %0d want 1", wr_cnt - w0); end
        n_checks++; if ({tcora_o, tcorb_o} !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL tcnt_write_side_effect_tcor got %h", {tcora_o, tcorb_o}); end
        n_checks++; if ({tcr_o, tccr_o, tcsr_o} !== 96'h0) begin n_fail++; $display("FAIL tcnt_write_side_effect_ctrl got %h want 0", {tcr_o, tccr_o, tcsr_o}); end
    endtask

    task automatic test_flag_clear();
        logic [7:0] rd, wd; logic er; logic [3:0] ws; int lat;
        @(negedge clk); cmfa_set_i = 4'b0001;
        @(negedge clk); cmfa_set_i = 4'b0000;
        n_checks++; if (tcsr_o[7:0] !== 8'h40) begin n_fail++; $display("FAIL cmfa_set got %h want 40", tcsr_o[7:0]); end
        do_access(1'b1, 5'b00101, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (tcsr_o[7:0] !== 8'h40) begin n_fail++; $display("FAIL cmfa_unarmed_write got %h want 40", tcsr_o[7:0]); end
        do_access(1'b0, 5'b00101, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (rd !== 8'h40) begin n_fail++; $display("FAIL cmfa_read got %h want 40", rd); end
        do_access(1'b1, 5'b00101, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (tcsr_o[7:0] !== 8'h00) begin n_fail++; $display("FAIL cmfa_armed_clear got %h want 00", tcsr_o[7:0]); end
    endtask

    task automatic test_set_wins();
        logic [7:0] rd, wd; logic er; logic [3:0] ws; int lat;
        @(negedge clk); ovf_set_i = 4'b1000;
        @(negedge clk); ovf_set_i = 4'b0000;
        do_access(1'b0, 5'b11101, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (rd !== 8'h20) begin n_fail++; $display("FAIL ovf3_read got %h want 20", rd); end
        do_access(1'b1, 5'b11101, 8'h00, 4'b1000, rd, er, ws, wd, lat);
        n_checks++; if (tcsr_o[31:24] !== 8'h20) begin n_fail++; $display("FAIL ovf3_set_wins got %h want 20", tcsr_o[31:24]); end
        do_access(1'b1, 5'b11101, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (tcsr_o[31:24] !== 8'h20) begin n_fail++; $display("FAIL ovf3_disarmed got %h want 20", tcsr_o[31:24]); end
    endtask

    task automatic test_tcsr_bits();
        logic [7:0] rd, wd; logic er; logic [3:0] ws; int lat;
        do_access(1'b1, 5'b01101, 8'hFF, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (tcsr_o[15:8] !== 8'h0F) begin n_fail++; $display("FAIL tcsr_write_ones got %h want 0f", tcsr_o[15:8]); end
        do_access(1'b0, 5'b01101, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (rd !== 8'h0F) begin n_fail++; $display("FAIL tcsr_read_os got %h want 0f", rd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd, wd; logic er; logic [3:0] ws; int lat;
        do_access(1'b1, 5'b11100, 8'h3C, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (tccr_o[31:24] !== 8'h3C) begin n_fail++; $display("FAIL tccr3_write got %h want 3c", tccr_o[31:24]); end
        do_access(1'b0, 5'b11100, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL tccr3_read got %h want 3c", rd); end
        do_access(1'b0, 5'b01010, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (rd !== 8'hFF) begin n_fail++; $display("FAIL tcorb1_read got %h want ff", rd); end
    endtask

    task automatic test_reserved();
        logic [7:0] rd, wd; logic er; logic [3:0] ws; int lat;
        tcnt_i = 32'h0000_3412;
`ifdef TIMER_BUS_16BIT_EN
        do_access(1'b0, 5'b00110, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if ({er, rd} !== 9'h012) begin n_fail++; $display("FAIL cnt16_lo got err=%b data=%h want 0/12", er, rd); end
        do_access(1'b0, 5'b00111, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if ({er, rd} !== 9'h034) begin n_fail++; $display("FAIL cnt16_hi got err=%b data=%h want 0/34", er, rd); end
        do_access(1'b0, 5'b01110, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if ({er, rd} !== 9'h100) begin n_fail++; $display("FAIL odd_reg6 got err=%b data=%h want 1/00", er, rd); end
`else
        do_access(1'b0, 5'b00110, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if ({er, rd} !== 9'h100) begin n_fail++; $display("FAIL reserved_read got err=%b data=%h want 1/00", er, rd); end
        do_access(1'b1, 5'b00111, 8'hAA, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL reserved_write_err got %b want 1", er); end
        n_checks++; if (tcora_o[7:0] !== 8'hFF || tcr_o[7:0] !== 8'h00) begin n_fail++; $display("FAIL reserved_write_ignored got %h/%h want ff/00", tcora_o[7:0], tcr_o[7:0]); end
`endif
        do_access(1'b0, 5'b10000, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL tcnt2_read got %h want 00", rd); end
        do_access(1'b0, 5'b01000, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (rd !== 8'h34) begin n_fail++; $display("FAIL tcnt1_read got %h want 34", rd); end
    endtask

    task automatic test_held_req();
        int a0, w0;
        a0 = ack_cnt; w0 = wr_cnt;
        @(negedge clk);
        bus.bus_req = 1'b1; bus.bus_we = 1'b1; bus.bus_addr = 5'b11000; bus.bus_wdata = 8'h77;
        repeat (10) @(negedge clk);
        bus.bus_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ack_cnt - a0 !== 1) begin n_fail++; $display("FAIL held_req_acks got %0d want 1", ack_cnt - a0); end
        n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL held_req_writes got %0d want 1", wr_cnt - w0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd, wd; logic er; logic [3:0] ws; int lat; int a0;
        do_access(1'b1, 5'b00001, 8'h11, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (tcora_o[7:0] !== 8'h11) begin n_fail++; $display("FAIL tcora0_write got %h want 11", tcora_o[7:0]); end
        do_access(1'b1, 5'b10011, 8'h07, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (tcr_o[23:16] !== 8'h07) begin n_fail++; $display("FAIL tcr2_write got %h want 07", tcr_o[23:16]); end
        a0 = ack_cnt;
        @(negedge clk);
        bus.bus_req = 1'b1; bus.bus_we = 1'b1; bus.bus_addr = 5'b00001; bus.bus_wdata = 8'h22;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.bus_ack !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ack got %b want 0", bus.bus_ack); end
        n_checks++; if (tcora_o !== 32'hFFFF_FFFF || tcr_o !== 32'h0 || tccr_o !== 32'h0) begin n_fail++; $display("FAIL mid_reset_regs got %h/%h/%h", tcora_o, tcr_o, tccr_o); end
        n_checks++; if (tcsr_o !== 32'h0) begin n_fail++; $display("FAIL mid_reset_tcsr got %h want 0", tcsr_o); end
        bus.bus_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ack_cnt - a0 !== 0) begin n_fail++; $display("FAIL mid_reset_lost_ack got %0d want 0", ack_cnt - a0); end
        do_access(1'b0, 5'b00001, 8'h00, 4'b0, rd, er, ws, wd, lat);
        n_checks++; if (rd !== 8'hFF || lat !== 2) begin n_fail++; $display("FAIL post_reset_read got %h lat %0d want ff lat 2", rd, lat); end
    endtask

    initial begin
        rst = 1'b1;
        bus.bus_req = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = 5'd0; bus.bus_wdata = 8'h00;
        tcnt_i = 32'h0;
        cmfa_set_i = 4'b0; cmfb_set_i = 4'b0; ovf_set_i = 4'b0;
        test_reset();
        test_read_tcora();
        test_tcnt_write();
        test_flag_clear();
        test_set_wins();
        test_tcsr_bits();
        test_back_to_back();
        test_reserved();
        test_held_req();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
